// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// hex font (active-high, {g,f,e,d,c,b,a}) and the slot FSM state type.
package seg_pkg;

  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } scan_state_e;

  localparam logic [0:15][6:0] SEG_FONT = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to seven-segment decode (active-high, {g,f,e,d,c,b,a}).
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_FONT[nibble];
  end

endmodule

// File: rtl/seg_dyn_scan.sv
// Dynamic multi-digit seven-segment scanner with shadowed, frame-synchronous load.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_dyn_scan
  import seg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int DIG_CYC     = 50_000,
  parameter int DEAD_CYC    = 16,
  parameter int SEG_ACT_LOW = 1,
  parameter int SEL_ACT_LOW = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(DIG_CYC);
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIG_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACT_LOW != 0) ? '1 : '0;
  localparam logic [7:0]        SEG_OFF  = (SEG_ACT_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  scan_state_e         state, state_nxt;
  logic [4*DIGITS-1:0] shadow, disp;
  logic [DIGITS-1:0]   shadow_dp, disp_dp;
  logic                pending;
  logic                slot_end, frame_end;
  logic [3:0]          nib;
  logic                dp_bit, suppress;
  logic [6:0]          font_segs;
  logic [DIGITS-1:0]   sel_c;
  logic [7:0]          seg_c;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= DEAD;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DEAD:    if (cnt == DEAD_LAST) state_nxt = SHOW;
      SHOW:    if (slot_end)         state_nxt = DEAD;
      default: state_nxt = DEAD;
    endcase
  end

  // Display register only swaps at frame end; a load on that same cycle bypasses the shadow.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
      disp      <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else begin
      if (load) begin
        shadow    <= data_in;
        shadow_dp <= dp_in;
      end
      if (frame_end) begin
        if (load) begin
          disp    <= data_in;
          disp_dp <= dp_in;
        end else if (pending) begin
          disp    <= shadow;
          disp_dp <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    nib    = '0;
    dp_bit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib    = disp[4*i +: 4];
        dp_bit = disp_dp[i];
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [IDX_W-1:0] hi;

  always_comb begin
    hi = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (disp[4*i +: 4] != 4'h0) hi = IDX_W'(i);
    end
    suppress = (idx > hi) && !dp_bit;
  end
`else
  always_comb begin
    suppress = 1'b0;
  end
`endif

  seg_hex_dec u_dec (
    .nibble (nib),
    .segs   (font_segs)
  );

  always_comb begin
    sel_c = '0;
    seg_c = '0;
    if (state == SHOW && !blank) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        sel_c[i] = (idx == IDX_W'(i));
      end
      if (!suppress) seg_c = {dp_bit, font_segs};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel        <= SEL_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      sel        <= sel_c ^ SEL_OFF;
      seg        <= seg_c ^ SEG_OFF;
      frame_done <= frame_end;
    end
  end

endmodule
